// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
//   Shared definitions for the registered instruction decode stage.
//   Contents:
//     OP_* - 3-bit opcode codes (000/001 are unassigned and decode as illegal)
//     decode_ctrl_t - width-independent control part of a decoded entry
//     is_rtype / is_itype - opcode class helpers
package decode_stage_pkg;

  localparam logic [2:0] OP_ILL0 = 3'b000;
  localparam logic [2:0] OP_ILL1 = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_ADDI = 3'b110;
  localparam logic [2:0] OP_ORI  = 3'b111;

  // Control fields of a decoded entry. The register-index and immediate
  // fields depend on module parameters and are added by the decode stage.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       reg_write;
    logic       alu_src;
    logic       illegal;
  } decode_ctrl_t;

  function automatic logic is_rtype(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_itype(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf
//   Generic 2-entry valid/ready skid buffer. Output is always driven from
//   the main register M; the skid register S absorbs one extra entry when
//   the consumer stalls. in_ready and out_valid are registered.
//   Ports:
//     clk, rst            - clock, asynchronous active-high reset
//     flush               - synchronous; drops all buffered entries
//     in_valid/in_ready   - producer handshake, in_data payload
//     out_valid/out_ready - consumer handshake, out_data payload
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t       state_reg;
  logic [W-1:0] m_reg;
  logic [W-1:0] s_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;

  logic accept;
  logic pop;

  assign accept = in_valid && in_ready_reg;
  assign pop    = out_valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      m_reg         <= '0;
      s_reg         <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      // Flush wins over any accept/pop in the same cycle.
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            m_reg         <= in_data;
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            s_reg        <= in_data;
            state_reg    <= TWO;
            in_ready_reg <= 1'b0;
          end else if (accept && pop) begin
            m_reg <= in_data;
          end else if (pop) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            m_reg        <= s_reg;
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = m_reg;

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered instruction decode stage: combinational field decode of
//   in_instr feeding a 2-entry skid buffer (1-cycle latency, 1/cycle).
//   Layout (O = INSTR_W-3): opcode [INSTR_W-1 -: 3], dest [O-1 -: REG_AW],
//   src1 [O-1-REG_AW -: REG_AW], src2 [O-1-2*REG_AW -: REG_AW], imm [IMM_W-1:0].
//   Ports:
//     clk, rst, flush        - clock, async active-high reset, sync flush
//     in_valid/in_ready      - fetch side handshake, in_instr word
//     out_valid/out_ready    - register file / ALU side handshake
//     out_rs/out_rt/out_rd   - register indices
//     out_imm                - extended immediate (0 for R-type / illegal)
//     out_alu_op, out_reg_write, out_alu_src, out_illegal - control
//   Build option: DECODE_IMM_SEXT_EN defined -> I-type immediate is sign-
//   extended to DATA_W; undefined -> zero-extended.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5,
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  out_rs,
  output logic [REG_AW-1:0]  out_rt,
  output logic [REG_AW-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_imm,
  output logic [2:0]         out_alu_op,
  output logic               out_reg_write,
  output logic               out_alu_src,
  output logic               out_illegal
);

  localparam int O = INSTR_W - 3;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] imm;
    decode_ctrl_t      ctrl;
  } entry_t;

  if (3 + 3*REG_AW > INSTR_W) begin : g_bad_reg_fields
    $error("decode_stage: opcode plus three register fields exceed INSTR_W");
  end
  if (IMM_W > INSTR_W - 3 - 2*REG_AW) begin : g_bad_imm_field
    $error("decode_stage: IMM_W overlaps the dest/src1 fields");
  end
  if (DATA_W < IMM_W) begin : g_bad_data_w
    $error("decode_stage: DATA_W must be >= IMM_W");
  end

  logic [2:0]        opcode;
  logic [REG_AW-1:0] dest;
  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic [IMM_W-1:0]  imm_field;
  logic [DATA_W-1:0] imm_ext;
  entry_t            dec;
  entry_t            out_entry;

  assign opcode    = in_instr[INSTR_W-1 -: 3];
  assign dest      = in_instr[O-1 -: REG_AW];
  assign src1      = in_instr[O-1-REG_AW -: REG_AW];
  assign src2      = in_instr[O-1-2*REG_AW -: REG_AW];
  assign imm_field = in_instr[IMM_W-1:0];

`ifdef DECODE_IMM_SEXT_EN
  assign imm_ext = DATA_W'($signed(imm_field));
`else
  assign imm_ext = DATA_W'(imm_field);
`endif

  always_comb begin
    dec = '0;
    if (is_rtype(opcode)) begin
      dec.rd             = dest;
      dec.rs             = src1;
      dec.rt             = src2;
      dec.ctrl.alu_op    = opcode;
      dec.ctrl.reg_write = 1'b1;
    end else if (is_itype(opcode)) begin
      dec.rt             = dest;
      dec.rs             = src1;
      dec.imm            = imm_ext;
      dec.ctrl.alu_op    = opcode;
      dec.ctrl.reg_write = 1'b1;
      dec.ctrl.alu_src   = 1'b1;
    end else begin
      // Illegal opcodes still travel down the pipe as an all-zero bubble.
      dec.ctrl.illegal = 1'b1;
    end
  end

  decode_skid_buf #(
    .W($bits(entry_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_entry)
  );

  assign out_rs        = out_entry.rs;
  assign out_rt        = out_entry.rt;
  assign out_rd        = out_entry.rd;
  assign out_imm       = out_entry.imm;
  assign out_alu_op    = out_entry.ctrl.alu_op;
  assign out_reg_write = out_entry.ctrl.reg_write;
  assign out_alu_src   = out_entry.ctrl.alu_src;
  assign out_illegal   = out_entry.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed scenarios plus randomized traffic for decode_stage, checked
//   against a queue-based reference model with arithmetic field decode.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [2:0]  out_alu_op;
  logic        out_reg_write;
  logic        out_alu_src;
  logic        out_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected entries in delivery order: {rs,rt,rd,imm,alu_op,reg_write,alu_src,illegal}
  logic [52:0] q[$];
  logic [52:0] dummy;
  logic [52:0] hold;
  logic [52:0] dut_payload;

  always #5 clk = ~clk;

  assign dut_payload = {out_rs, out_rt, out_rd, out_imm, out_alu_op,
                        out_reg_write, out_alu_src, out_illegal};

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_imm      (out_imm),
    .out_alu_op   (out_alu_op),
    .out_reg_write(out_reg_write),
    .out_alu_src  (out_alu_src),
    .out_illegal  (out_illegal)
  );

  function automatic logic [52:0] ref_decode(input logic [31:0] instr);
    int unsigned op, dst, s1, s2;
    logic [31:0] imm;
    op  = instr >> 29;
    dst = (instr >> 24) & 31;
    s1  = (instr >> 19) & 31;
    s2  = (instr >> 14) & 31;
    imm = instr & 32'h0000FFFF;
`ifdef DECODE_IMM_SEXT_EN
    if (imm >= 32'h8000) imm = imm | 32'hFFFF0000;
`endif
    if (op >= 2 && op <= 5)
      return {5'(s1), 5'(s2), 5'(dst), 32'd0, 3'(op), 1'b1, 1'b0, 1'b0};
    if (op >= 6)
      return {5'(s1), 5'(dst), 5'd0, imm, 3'(op), 1'b1, 1'b1, 1'b0};
    return {47'd0, 3'd0, 1'b0, 1'b0, 1'b1};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after a falling edge, update the model at
  // the rising edge, compare outputs at the next falling edge.
  task automatic step(input logic v, input logic [31:0] instr, input logic r, input logic f);
    logic acc, pop;
    in_valid  = v;
    in_instr  = instr;
    out_ready = r;
    flush     = f;
    acc = v && (q.size() < 2);
    pop = (q.size() > 0) && r;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (pop) dummy = q.pop_front();
      if (acc) q.push_back(ref_decode(instr));
    end
    @(negedge clk);
    check_eq("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    check_eq("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) check_eq("payload", {11'd0, dut_payload}, {11'd0, q[0]});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    #12;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_payload", {11'd0, dut_payload}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // R-type and back-to-back throughput
    step(1'b1, 32'h4A14C000, 1'b1, 1'b0);
    check_eq("r_valid", {63'd0, out_valid}, 64'd1);
    check_eq("r_alu_op", {61'd0, out_alu_op}, 64'd2);
    check_eq("r_rd", {59'd0, out_rd}, 64'd10);
    check_eq("r_rs", {59'd0, out_rs}, 64'd2);
    check_eq("r_rt", {59'd0, out_rt}, 64'd19);
    check_eq("r_ctl", {62'd0, out_reg_write, out_alu_src}, 64'd2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, {3'(2 + $urandom % 4), 29'($urandom)}, 1'b1, 1'b0);
      check_eq("thru_valid", {63'd0, out_valid}, 64'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // I-type immediate extension
    step(1'b1, 32'hC518FFFC, 1'b1, 1'b0);
    check_eq("i_rt", {59'd0, out_rt}, 64'd5);
    check_eq("i_rs", {59'd0, out_rs}, 64'd3);
    check_eq("i_alu_op", {61'd0, out_alu_op}, 64'd6);
    check_eq("i_alu_src", {63'd0, out_alu_src}, 64'd1);
`ifdef DECODE_IMM_SEXT_EN
    check_eq("i_imm", {32'd0, out_imm}, 64'hFFFFFFFC);
`else
    check_eq("i_imm", {32'd0, out_imm}, 64'h0000FFFC);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: two accepted, third refused, payload held
    step(1'b1, 32'h4A14C000, 1'b0, 1'b0);
    check_eq("bp_ready1", {63'd0, in_ready}, 64'd1);
    step(1'b1, 32'hC518FFFC, 1'b0, 1'b0);
    check_eq("bp_ready2", {63'd0, in_ready}, 64'd0);
    hold = dut_payload;
    step(1'b1, 32'h6A14C000, 1'b0, 1'b0);
    check_eq("bp_hold", {11'd0, dut_payload}, {11'd0, hold});
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check_eq("bp_second", {11'd0, dut_payload}, {11'd0, ref_decode(32'hC518FFFC)});
    check_eq("bp_ready_back", {63'd0, in_ready}, 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Illegal opcodes flow through as bubbles
    step(1'b1, 32'h00000000, 1'b1, 1'b0);
    check_eq("ill0", {10'd0, out_valid, dut_payload}, {10'd0, 1'b1, 53'd1});
    step(1'b1, 32'h3FFFFFFF, 1'b1, 1'b0);
    check_eq("ill1", {10'd0, out_valid, dut_payload}, {10'd0, 1'b1, 53'd1});
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush from TWO, racing an accept and a pop
    step(1'b1, 32'h4A14C000, 1'b0, 1'b0);
    step(1'b1, 32'h5A14C000, 1'b0, 1'b0);
    step(1'b1, 32'hC518FFFC, 1'b1, 1'b1);
    check_eq("fl_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fl_ready", {63'd0, in_ready}, 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle
    step(1'b1, 32'h4A14C000, 1'b0, 1'b0);
    step(1'b1, 32'hC518FFFC, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("arst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst_payload", {11'd0, dut_payload}, 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, ($urandom % 40) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Sits between instruction fetch and the register file / ALU; decodes one instruction per cycle.
- Has a valid/ready handshake on both sides, a 2-entry skid buffer, flush, illegal-opcode flagging and immediate extension.
- Field layout generalises the existing 32-bit format:
  - opcode in the top 3 bits, then dest, src1, src2 fields;
  - immediate in the low bits.

Parameters:
- INSTR_W, 32, instruction width.
- REG_AW, 5, register index width.
- IMM_W, 16, immediate field width.
- DATA_W, 32, extended immediate width; must be >= IMM_W.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous; drops all buffered entries.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept.
- in_instr  input  INSTR_W  instruction word.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  consumer accepts.
- out_rs  output  REG_AW  source 1 index.
- out_rt  output  REG_AW  source 2 / I-type destination index.
- out_rd  output  REG_AW  R-type destination index.
- out_imm  output  DATA_W  extended immediate.
- out_alu_op  output  3  opcode.
- out_reg_write  output  1  writes register file.
- out_alu_src  output  1  1 = immediate operand.
- out_illegal  output  1  opcode not R/I.

Behaviour:
- Fields, with O = INSTR_W-3:
  - dest = [O-1 -: REG_AW]
  - src1 = [O-1-REG_AW -: REG_AW]
  - src2 = [O-1-2*REG_AW -: REG_AW]
  - imm = [IMM_W-1:0]
- Elaboration-time checks: 3+3*REG_AW <= INSTR_W and IMM_W <= INSTR_W-3-2*REG_AW.
- Opcodes 010/011/100/101 are R-type:
  - rd=dest, rs=src1, rt=src2, reg_write=1, alu_src=0, imm=0, alu_op=opcode.
- Opcodes 110/111 are I-type:
  - rt=dest, rs=src1, rd=0, imm=zero-extended immediate, reg_write=1, alu_src=1, alu_op=opcode.
- Opcodes 000/001 are illegal:
  - all fields 0, reg_write=0, alu_op=0, illegal=1;
  - the entry still flows through as a bubble and is not dropped.
- Decode is combinational on in_instr; the result is captured into the buffer on in_valid && in_ready.
- Buffer: main register M plus skid register S; state EMPTY/ONE/TWO.
  - Outputs always driven from M.
  - in_ready = (state != TWO), registered.
  - EMPTY + accept -> ONE.
  - ONE + accept with no pop -> TWO; new entry goes to S.
  - ONE + accept with pop -> ONE; M <= new entry.
  - ONE + pop with no accept -> EMPTY.
  - TWO + pop -> ONE; M <= S. There is no accept in TWO.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1/cycle when out_ready is held high.
- Payload on out_* is stable while out_valid && !out_ready.
- flush has priority over accept and pop in the same cycle:
  - next state EMPTY; the in-flight input is discarded.
- rst, asynchronous: state EMPTY, in_ready=1, all out_* = 0.
  - Reset asserted mid-transfer discards everything.
- Payload registers are don't-care when out_valid=0 but are reset to 0.

Optional Feature:
- Macro: DECODE_IMM_SEXT_EN.
- Defined: I-type immediate is sign-extended to DATA_W (bit IMM_W-1 replicated).
- Undefined: I-type immediate is zero-extended.
- R-type and illegal entries keep out_imm=0 in both cases.

Decomposition:
- Shared package holds the opcode localparams:
  - OP_ADD..OP_xxx for the 3-bit codes;
  - an is_rtype/is_itype function;
  - the packed decoded-entry struct (rs, rt, rd, imm, alu_op, reg_write, alu_src, illegal).
- One sub-module: decode_skid_buf, a generic 2-entry valid/ready skid buffer parametrised on payload width.
- decode_stage = combinational decode + decode_skid_buf.

Test Plan:
- R-type throughput: in_instr=0x4A14C000 streamed with out_ready=1 -> 1 cycle later out_valid=1, out_alu_op=010, out_rd=10, out_rs=2, out_rt=19, reg_write=1, alu_src=0; back-to-back instructions delivered 1/cycle.
- I-type extension: in_instr=0xC518FFFC -> rt=5, rs=3, alu_op=110, alu_src=1.
  - out_imm=0x0000FFFC without the macro.
  - out_imm=0xFFFFFFFC with DECODE_IMM_SEXT_EN defined.
- Backpressure: out_ready=0, three instructions offered -> two accepted, in_ready=0 after the second; out_* stable. out_ready=1 -> delivered in order, in_ready returns 1.
- Illegal opcode: in_instr=0x00000000 or 0x3FFFFFFF -> out_valid=1, out_illegal=1, reg_write=0, all fields 0.
- Flush and reset: state TWO, then flush=1 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, nothing emitted. Async rst asserted mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
